// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the core memory
// stage and a debug/loader port.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_*                     core load/store request (byte/half/word), gnt is
//                              combinational, rvalid/rdata/err one cycle later
//   dbg_*                      debug word access; dbg_halt locks the core out,
//                              dbg_halted reports the lock
//   mem_*                      memory array interface (word index, byte
//                              enables, lane-replicated write data)
//
// Arbitration: core has priority, but after MAX_CORE_RUN consecutive core
// grants with debug waiting, debug wins one cycle. While halted only debug is
// served.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MAX_CORE_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [1:0]        core_size,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    output logic              core_err,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_halt,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_halted,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StRun, StHaltPend, StHalted} state_e;

    localparam logic [3:0] MaxRun = 4'(MAX_CORE_RUN);

    state_e      state_q, state_d;
    logic [3:0]  core_run_q, core_run_d;
    logic        core_rvalid_q, core_rvalid_d;
    logic        core_err_q, core_err_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        dbg_halted_q, dbg_halted_d;

    logic        core_ok;
    logic [3:0]  core_be;
    logic [31:0] core_wd;

    // Word access from debug: byte lanes are never used.
    logic unused_dbg_lsbs;
    assign unused_dbg_lsbs = ^dbg_addr[1:0];

    // Size/alignment decode of the core request.
    always_comb begin
        core_ok = 1'b0;
        core_be = 4'b0000;
        core_wd = 32'h0;
        case (core_size)
            2'b00: begin
                core_ok = 1'b1;
                core_be = 4'b0001 << core_addr[1:0];
                core_wd = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                core_ok = ~core_addr[0];
                core_be = core_addr[1] ? 4'b1100 : 4'b0011;
                core_wd = {2{core_wdata[15:0]}};
            end
            2'b10: begin
                core_ok = (core_addr[1:0] == 2'b00);
                core_be = 4'b1111;
                core_wd = core_wdata;
            end
            default: begin
                core_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        core_run_d    = core_run_q;
        core_gnt      = 1'b0;
        dbg_gnt       = 1'b0;
        mem_rd_en     = 1'b0;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_be        = 4'b0000;
        mem_wdata     = 32'h0;

        unique case (state_q)
            StRun:      if (dbg_halt) state_d = StHaltPend;
            StHaltPend: state_d = dbg_halt ? StHalted : StRun;
            StHalted:   if (!dbg_halt) state_d = StRun;
            default:    state_d = StRun;
        endcase

        // Grants are gated by rst_n so nothing reaches memory while in reset.
        core_gnt = rst_n && core_req && (state_q != StHalted) &&
                   !(dbg_req && (core_run_q == MaxRun));
        dbg_gnt  = rst_n && dbg_req && !core_gnt;

        if (dbg_gnt || !dbg_req) begin
            core_run_d = 4'd0;
        end else if (core_gnt && (core_run_q != MaxRun)) begin
            core_run_d = core_run_q + 4'd1;
        end

        // Illegal core accesses are consumed without touching memory.
        if (core_gnt && core_ok) begin
            mem_rd_en = ~core_we;
            mem_wr_en = core_we;
            mem_addr  = core_addr[ADDR_W-1:2];
            mem_be    = core_we ? core_be : 4'b0000;
            mem_wdata = core_we ? core_wd : 32'h0;
        end else if (dbg_gnt) begin
            mem_rd_en = ~dbg_we;
            mem_wr_en = dbg_we;
            mem_addr  = dbg_addr[ADDR_W-1:2];
            mem_be    = dbg_we ? 4'b1111 : 4'b0000;
            mem_wdata = dbg_we ? dbg_wdata : 32'h0;
        end

        core_rvalid_d = core_gnt;
        core_err_d    = core_gnt && !core_ok;
        core_rdata_d  = (core_gnt && core_ok && !core_we) ? mem_rdata : 32'h0;
        dbg_rvalid_d  = dbg_gnt;
        dbg_rdata_d   = (dbg_gnt && !dbg_we) ? mem_rdata : 32'h0;
        dbg_halted_d  = (state_d == StHalted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            core_run_q    <= 4'd0;
            core_rvalid_q <= 1'b0;
            core_err_q    <= 1'b0;
            core_rdata_q  <= 32'h0;
            dbg_rvalid_q  <= 1'b0;
            dbg_rdata_q   <= 32'h0;
            dbg_halted_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_run_q    <= core_run_d;
            core_rvalid_q <= core_rvalid_d;
            core_err_q    <= core_err_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            dbg_rdata_q   <= dbg_rdata_d;
            dbg_halted_q  <= dbg_halted_d;
        end
    end

    assign core_rvalid = core_rvalid_q;
    assign core_err    = core_err_q;
    assign core_rdata  = core_rdata_q;
    assign dbg_rvalid  = dbg_rvalid_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign dbg_halted  = dbg_halted_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural model predicts grants, memory
// strobes and the delayed responses; a monitor pops the response queues.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int MAXRUN = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_req = 1'b0, core_we = 1'b0;
    logic [1:0]        core_size = 2'b00;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [31:0]       core_wdata = '0;
    logic              core_gnt, core_rvalid, core_err;
    logic [31:0]       core_rdata;
    logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_halt = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic              dbg_gnt, dbg_rvalid, dbg_halted;
    logic [31:0]       dbg_rdata;
    logic              mem_rd_en, mem_wr_en;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_CORE_RUN(MAXRUN)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_halt(dbg_halt), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_halted(dbg_halted),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory array the DUT drives.
    logic [31:0] tb_mem [256] = '{default: '0};
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [7:0] ref_mem [1024] = '{default: '0};
    int halt_cnt = 0;   // consecutive earlier cycles with dbg_halt high (sat. 2)
    int run_cnt = 0;    // consecutive core wins while debug waited

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t core_q[$];
    resp_t dbg_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    task automatic do_cycle(input logic creq, input logic cwe, input logic [1:0] csz,
                            input logic [9:0] caddr, input logic [31:0] cwd,
                            input logic dreq, input logic dwe, input logic [9:0] daddr,
                            input logic [31:0] dwd, input logic dhalt,
                            output logic cg_act, output logic dg_act);
        logic cg, dg, ok, rd, wr;
        logic [7:0] idx;
        logic [3:0] be;
        logic [31:0] wd;
        resp_t r;
        int a, nb;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        core_req = creq; core_we = cwe; core_size = csz; core_addr = caddr;
        core_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd; dbg_halt = dhalt;
        #3;
        if (halt_cnt >= 2) begin
            cg = 1'b0;
            dg = dreq;
        end else begin
            cg = creq && !(dreq && run_cnt == MAXRUN);
            dg = dreq && !cg;
        end
        a  = int'(caddr[1:0]);
        nb = 1 << csz;
        ok = (csz != 2'd3) && (a % nb == 0);
        rd = 1'b0; wr = 1'b0; idx = '0; be = '0; wd = '0;
        if (cg && ok) begin
            rd  = !cwe;
            wr  = cwe;
            idx = caddr[9:2];
            if (cwe) begin
                be = 4'(((1 << nb) - 1) << a);
                for (int i = 0; i < 4; i++) wd[8*i +: 8] = cwd[8*(i % nb) +: 8];
            end
        end else if (dg) begin
            rd  = !dwe;
            wr  = dwe;
            idx = daddr[9:2];
            if (dwe) begin
                be = 4'hf;
                wd = dwd;
            end
        end
        check("core_gnt", core_gnt, cg);
        check("dbg_gnt", dbg_gnt, dg);
        check("mem_rd_en", mem_rd_en, rd);
        check("mem_wr_en", mem_wr_en, wr);
        check("mem_addr", mem_addr, idx);
        check("mem_be", mem_be, be);
        check("mem_wdata", mem_wdata, wd);
        check("dbg_halted", dbg_halted, halt_cnt >= 2);
        cg_act = core_gnt;
        dg_act = dbg_gnt;
        if (cg) begin
            r.due   = cyc + 1;
            r.rdata = (ok && !cwe) ? ref_word(int'(caddr[9:2])) : 32'h0;
            r.err   = !ok;
            core_q.push_back(r);
        end
        if (dg) begin
            r.due   = cyc + 1;
            r.rdata = !dwe ? ref_word(int'(daddr[9:2])) : 32'h0;
            r.err   = 1'b0;
            dbg_q.push_back(r);
        end
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ref_mem[4*int'(idx)+i] = wd[8*i +: 8];
            end
        end
        if (dg || !dreq) run_cnt = 0;
        else if (cg && run_cnt < MAXRUN) run_cnt++;
        halt_cnt = dhalt ? ((halt_cnt < 2) ? halt_cnt + 1 : 2) : 0;
    endtask

    // Holds reset for n cycles with both requesters asserting; leaves rst_n low
    // so the following do_cycle releases it together with its stimulus.
    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            core_req = 1'b1; core_we = 1'b1; core_size = 2'b10; core_addr = 10'h004;
            dbg_req = 1'b1; dbg_halt = 1'b0;
            core_q.delete();
            dbg_q.delete();
            halt_cnt = 0;
            run_cnt = 0;
            #3;
            check("rst_core_gnt", core_gnt, 1'b0);
            check("rst_dbg_gnt", dbg_gnt, 1'b0);
            check("rst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
            check("rst_rvalid", {core_rvalid, dbg_rvalid, core_err}, 3'b000);
            check("rst_halted", dbg_halted, 1'b0);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        resp_t r;
        if (core_rvalid) begin
            if (core_q.size() == 0) begin
                check("core_rvalid_unexpected", core_rvalid, 1'b0);
            end else begin
                r = core_q.pop_front();
                check("core_resp_cycle", cyc, r.due);
                check("core_rdata", core_rdata, r.rdata);
                check("core_err", core_err, r.err);
            end
        end else begin
            check("core_err_idle", core_err, 1'b0);
            if (core_q.size() > 0 && core_q[0].due <= cyc) begin
                check("core_rvalid_missing", core_rvalid, 1'b1);
                void'(core_q.pop_front());
            end
        end
        if (dbg_rvalid) begin
            if (dbg_q.size() == 0) begin
                check("dbg_rvalid_unexpected", dbg_rvalid, 1'b0);
            end else begin
                r = dbg_q.pop_front();
                check("dbg_resp_cycle", cyc, r.due);
                check("dbg_rdata", dbg_rdata, r.rdata);
            end
        end else if (dbg_q.size() > 0 && dbg_q[0].due <= cyc) begin
            check("dbg_rvalid_missing", dbg_rvalid, 1'b1);
            void'(dbg_q.pop_front());
        end
    end

    initial begin
        logic cg, dg;
        logic creq, cwe, dreq, dwe, dhalt;
        logic [1:0] csz;
        logic [9:0] caddr, daddr;
        logic [31:0] cwd, dwd;
        string pat;

        do_reset(3);
        // Store byte, then misaligned store word.
        do_cycle(1, 1, 2'b00, 10'h006, 32'h0000_00ab, 0, 0, 10'h0, 32'h0, 0, cg, dg);
        do_cycle(1, 1, 2'b10, 10'h002, 32'hdead_beef, 0, 0, 10'h0, 32'h0, 0, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h004, 32'h0, 0, 0, 10'h0, 32'h0, 0, cg, dg);
        do_cycle(0, 0, 2'b00, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 0, cg, dg);

        // Starvation bound with both requesters held.
        pat = "";
        for (int i = 0; i < 10; i++) begin
            do_cycle(1, 0, 2'b10, 10'h000, 32'h0, 1, 0, 10'h004, 32'h0, 0, cg, dg);
            pat = {pat, cg ? "C" : (dg ? "D" : "-")};
        end
        checks++;
        if (pat != "CCCCDCCCCD") begin
            failures++;
            $display("FAIL grant_pattern actual=%s required=CCCCDCCCCD", pat);
        end

        // Halt during core streaming, debug write and readback, release.
        do_cycle(1, 0, 2'b10, 10'h008, 32'h0, 0, 0, 10'h0, 32'h0, 0, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h008, 32'h0, 0, 0, 10'h0, 32'h0, 1, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h008, 32'h0, 0, 0, 10'h0, 32'h0, 1, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h008, 32'h0, 1, 1, 10'h010, 32'h1234_5678, 1, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h008, 32'h0, 1, 0, 10'h010, 32'h0, 1, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h008, 32'h0, 0, 0, 10'h0, 32'h0, 0, cg, dg);
        do_cycle(1, 0, 2'b10, 10'h010, 32'h0, 0, 0, 10'h0, 32'h0, 0, cg, dg);

        // Randomised traffic; requests are held until granted.
        creq = 0; cwe = 0; csz = 0; caddr = 0; cwd = 0;
        dreq = 0; dwe = 0; daddr = 0; dwd = 0; dhalt = 0;
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                do_reset(2);
                creq = 0;
                dreq = 0;
            end
            if (!creq) begin
                creq  = ($urandom_range(0, 3) != 0);
                cwe   = 1'($urandom_range(0, 1));
                csz   = 2'($urandom_range(0, 3));
                caddr = 10'($urandom_range(0, 63));
                if (csz != 2'd3 && $urandom_range(0, 3) != 0)
                    caddr = caddr & ~(10'((1 << csz) - 1));
                cwd   = $urandom;
            end
            if (!dreq) begin
                dreq  = ($urandom_range(0, 2) == 0);
                dwe   = 1'($urandom_range(0, 1));
                daddr = 10'($urandom_range(0, 63));
                dwd   = $urandom;
            end
            if ($urandom_range(0, 15) == 0) dhalt = ~dhalt;
            do_cycle(creq, cwe, csz, caddr, cwd, dreq, dwe, daddr, dwd, dhalt, cg, dg);
            if (cg) creq = 0;
            if (dg) dreq = 0;
        end

        for (int i = 0; i < 3; i++)
            do_cycle(0, 0, 2'b00, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 0, cg, dg);
        @(posedge clk);
        #4;
        check("core_q_drained", 32'(core_q.size()), 32'd0);
        check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
